// File: rtl/sm2201_camac_cycle_sequencer.sv
// sm2201_camac_cycle_sequencer
//
// Turns 8-bit ISA I/O accesses in a 64-byte window into 16-bit CAMAC dataway
// cycles. Odd/even byte pairs at offsets 2n/2n+1 map to CAMAC subaddress n.
//
// A write to the low byte is only buffered. A write to the high byte runs a
// CAMAC write of {high, low}. A read of the low byte runs a CAMAC read. A read
// of the high byte returns the upper half of the word latched by that read.
// isa_chrdy is held low while a CAMAC cycle is in flight.
//
// Ports
//   isa_clk, isa_reset        clock, synchronous active-high reset
//   isa_aen                   DMA cycle, bus ignored while high
//   isa_ior, isa_iow          I/O strobes, active low
//   isa_addr, isa_data_in     I/O address and write byte
//   isa_data_out, isa_data_oe read byte and its bus enable
//   isa_chrdy                 channel ready, low inserts wait states
//   cb_addr, cb_write         CAMAC subaddress and direction
//   cb_strobe                 CAMAC strobe
//   cb_data_out, cb_data_in   CAMAC write and read words
//   cb_busy, cb_x             dataway busy, command accepted
//   x_status                  cb_x captured at the end of the last strobe
//   cycle_err                 last CAMAC cycle timed out waiting for cb_busy
//
// state  | meaning
// IDLE   | waiting for a strobe falling edge inside the window
// SETUP  | cb_addr/cb_write valid, waiting for cb_busy low (timeout bounded)
// STROBE | cb_strobe high for STROBE_CYCLES cycles
// HOLD   | strobe low, address/data held one more cycle
// DONE   | chrdy high, read byte driven; waits for both strobes released

module sm2201_camac_cycle_sequencer #(
  parameter logic [9:0] BASE_ADDR      = 10'h100,
  parameter int         STROBE_CYCLES  = 4,
  parameter int         TIMEOUT_CYCLES = 32
) (
  input  logic        isa_clk,
  input  logic        isa_reset,
  input  logic        isa_aen,
  input  logic        isa_ior,
  input  logic        isa_iow,
  input  logic [9:0]  isa_addr,
  input  logic [7:0]  isa_data_in,
  output logic [7:0]  isa_data_out,
  output logic        isa_data_oe,
  output logic        isa_chrdy,
  output logic [4:0]  cb_addr,
  output logic        cb_write,
  output logic        cb_strobe,
  output logic [15:0] cb_data_out,
  input  logic [15:0] cb_data_in,
  input  logic        cb_busy,
  input  logic        cb_x,
  output logic        x_status,
  output logic        cycle_err
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t      state;
  logic        ior_q, iow_q, ior_qq, iow_qq;
  logic        is_read;
  logic [7:0]  low_buf;
  logic [15:0] read_latch;
  logic [7:0]  cnt;

  logic [9:0]  offset;
  logic        in_range;
  logic        ior_fall, iow_fall;
  logic        start;
  logic        trigger;

  // BASE_ADDR is 64-byte aligned, so the window check reduces to the
  // upper offset bits being zero (wrap-around below BASE lands out of range).
  assign offset   = isa_addr - BASE_ADDR;
  assign in_range = (offset[9:6] == 4'd0);

  // Edges are taken on the registered strobes so a single glitch-free sample
  // of each pin is used throughout.
  assign ior_fall = ior_qq & ~ior_q;
  assign iow_fall = iow_qq & ~iow_q;
  assign start    = (state == IDLE) && !isa_aen && in_range &&
                    ((ior_fall && iow_q) || (iow_fall && ior_q));

  // Low-byte reads and high-byte writes are the accesses that touch CAMAC.
  assign trigger  = ior_fall ? ~offset[0] : offset[0];

  always_ff @(posedge isa_clk) begin
    if (isa_reset) begin
      state        <= IDLE;
      ior_q        <= 1'b1;
      iow_q        <= 1'b1;
      ior_qq       <= 1'b1;
      iow_qq       <= 1'b1;
      is_read      <= 1'b0;
      low_buf      <= 8'h00;
      read_latch   <= 16'h0000;
      cnt          <= 8'd0;
      isa_data_out <= 8'h00;
      isa_data_oe  <= 1'b0;
      isa_chrdy    <= 1'b1;
      cb_addr      <= 5'd0;
      cb_write     <= 1'b0;
      cb_strobe    <= 1'b0;
      cb_data_out  <= 16'h0000;
      x_status     <= 1'b0;
      cycle_err    <= 1'b0;
    end else begin
      ior_q  <= isa_ior;
      iow_q  <= isa_iow;
      ior_qq <= ior_q;
      iow_qq <= iow_q;

      unique case (state)
        IDLE: begin
          if (start) begin
            is_read <= ior_fall;
            if (trigger) begin
              cb_addr   <= offset[5:1];
              cb_write  <= ~ior_fall;
              if (!ior_fall)
                cb_data_out <= {isa_data_in, low_buf};
              isa_chrdy <= 1'b0;
              cnt       <= 8'(TIMEOUT_CYCLES - 1);
              state     <= SETUP;
            end else begin
              if (ior_fall) begin
                isa_data_out <= read_latch[15:8];
                isa_data_oe  <= 1'b1;
              end else begin
                low_buf <= isa_data_in;
              end
              state <= DONE;
            end
          end
        end

        SETUP: begin
          if (!cb_busy) begin
            cb_strobe <= 1'b1;
            cnt       <= 8'(STROBE_CYCLES - 1);
            state     <= STROBE;
          end else if (cnt == 8'd0) begin
            // Abort: the host still gets a defined byte and a released bus.
            cycle_err  <= 1'b1;
            read_latch <= 16'hFFFF;
            isa_chrdy  <= 1'b1;
            if (is_read) begin
              isa_data_out <= 8'hFF;
              isa_data_oe  <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        STROBE: begin
          if (cnt == 8'd0) begin
            cb_strobe <= 1'b0;
            x_status  <= cb_x;
            cycle_err <= 1'b0;
            if (is_read)
              read_latch <= cb_data_in;
            state <= HOLD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        HOLD: begin
          isa_chrdy <= 1'b1;
          // Only low-byte reads reach here, so the low half is the answer.
          if (is_read) begin
            isa_data_out <= read_latch[7:0];
            isa_data_oe  <= 1'b1;
          end
          state <= DONE;
        end

        DONE: begin
          if (ior_q && iow_q) begin
            isa_data_oe <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm2201_camac_cycle_sequencer.sv
module tb_sm2201_camac_cycle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        aen;
  logic        ior;
  logic        iow;
  logic [9:0]  addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        oe;
  logic        chrdy;
  logic [4:0]  cb_addr;
  logic        cb_write;
  logic        cb_strobe;
  logic [15:0] cb_data_out;
  logic [15:0] cb_data_in;
  logic        cb_busy;
  logic        cb_x;
  logic        x_status;
  logic        cycle_err;

  int n_assert = 0;
  int n_fail   = 0;

  // per-access observations
  int          low_cnt, stb_cnt, rises;
  logic [7:0]  rd_byte;
  logic        rd_oe;
  logic [4:0]  a_cap;
  logic        w_cap;
  logic [15:0] d_cap;

  always #5 clk = ~clk;

  sm2201_camac_cycle_sequencer dut (
    .isa_clk      (clk),
    .isa_reset    (rst),
    .isa_aen      (aen),
    .isa_ior      (ior),
    .isa_iow      (iow),
    .isa_addr     (addr),
    .isa_data_in  (din),
    .isa_data_out (dout),
    .isa_data_oe  (oe),
    .isa_chrdy    (chrdy),
    .cb_addr      (cb_addr),
    .cb_write     (cb_write),
    .cb_strobe    (cb_strobe),
    .cb_data_out  (cb_data_out),
    .cb_data_in   (cb_data_in),
    .cb_busy      (cb_busy),
    .cb_x         (cb_x),
    .x_status     (x_status),
    .cycle_err    (cycle_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One ISA access: strobe(s) asserted at a falling clock edge, outputs sampled
  // on every following falling edge until chrdy has dropped and recovered (or
  // a few cycles pass with no wait state), then strobes released.
  task automatic access(input logic wr, input logic both, input logic a_en,
                        input logic [9:0] a, input logic [7:0] d);
    logic prev_stb;
    logic seen_low;
    logic ended;
    low_cnt = 0; stb_cnt = 0; rises = 0;
    a_cap = 5'h1F; w_cap = 1'bx; d_cap = 16'hxxxx;
    prev_stb = 1'b0; seen_low = 1'b0; ended = 1'b0;
    @(negedge clk);
    addr = a; din = d; aen = a_en;
    if (both) begin ior = 1'b0; iow = 1'b0; end
    else if (wr) iow = 1'b0;
    else ior = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (cb_strobe) begin
        stb_cnt++;
        if (!prev_stb) begin
          rises++;
          a_cap = cb_addr; w_cap = cb_write; d_cap = cb_data_out;
        end
      end
      prev_stb = cb_strobe;
      if (!chrdy) begin low_cnt++; seen_low = 1'b1; end
      if ((seen_low && chrdy) || (!seen_low && i >= 4)) begin
        ended = 1'b1;
        break;
      end
    end
    if (!ended) check("access_bound", 32'd0, 32'd1);
    rd_byte = dout;
    rd_oe   = oe;
    // Garbage on the bus after the start edge must not matter.
    addr = 10'h3FF; din = 8'hAA;
    ior = 1'b1; iow = 1'b1; aen = 1'b0;
    repeat (3) @(negedge clk);
    check("oe_release", {31'd0, oe}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; aen = 1'b0; ior = 1'b1; iow = 1'b1;
    addr = 10'h000; din = 8'h00;
    cb_data_in = 16'h0000; cb_busy = 1'b0; cb_x = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_dout",     {24'd0, dout},        32'h00);
    check("rst_oe",       {31'd0, oe},          32'd0);
    check("rst_chrdy",    {31'd0, chrdy},       32'd1);
    check("rst_cb_addr",  {27'd0, cb_addr},     32'd0);
    check("rst_cb_write", {31'd0, cb_write},    32'd0);
    check("rst_strobe",   {31'd0, cb_strobe},   32'd0);
    check("rst_cb_data",  {16'd0, cb_data_out}, 32'h0000);
    check("rst_x",        {31'd0, x_status},    32'd0);
    check("rst_err",      {31'd0, cycle_err},   32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // reset held two cycles in the middle of a strobe
    addr = 10'h102; ior = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_strobe_high", {31'd0, cb_strobe}, 32'd1);
    check("mid_chrdy_low",   {31'd0, chrdy},     32'd0);
    rst = 1'b1; ior = 1'b1;
    @(negedge clk);
    check("mrst_strobe",  {31'd0, cb_strobe}, 32'd0);
    check("mrst_chrdy",   {31'd0, chrdy},     32'd1);
    check("mrst_oe",      {31'd0, oe},        32'd0);
    check("mrst_cb_addr", {27'd0, cb_addr},   32'd0);
    @(negedge clk);
    check("mrst2_strobe", {31'd0, cb_strobe}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle_strobe", {31'd0, cb_strobe}, 32'd0);

    // write low then high byte
    cb_busy = 1'b0; cb_x = 1'b1;
    access(1'b1, 1'b0, 1'b0, 10'h104, 8'h08);
    check("wlo_chrdy_low", low_cnt, 32'd0);
    check("wlo_strobes",   stb_cnt, 32'd0);
    access(1'b1, 1'b0, 1'b0, 10'h105, 8'h42);
    check("whi_chrdy_low", low_cnt,            32'd6);
    check("whi_strobes",   stb_cnt,            32'd4);
    check("whi_rises",     rises,              32'd1);
    check("whi_cb_addr",   {27'd0, a_cap},     32'd2);
    check("whi_cb_write",  {31'd0, w_cap},     32'd1);
    check("whi_cb_data",   {16'd0, d_cap},     32'h4208);
    check("whi_oe",        {31'd0, rd_oe},     32'd0);
    check("whi_x",         {31'd0, x_status},  32'd1);
    check("whi_err",       {31'd0, cycle_err}, 32'd0);

    // read low then high byte at the top of the window
    cb_data_in = 16'h4208;
    access(1'b0, 1'b0, 1'b0, 10'h13E, 8'h00);
    check("rlo_chrdy_low", low_cnt,          32'd6);
    check("rlo_strobes",   stb_cnt,          32'd4);
    check("rlo_cb_addr",   {27'd0, a_cap},   32'd31);
    check("rlo_cb_write",  {31'd0, w_cap},   32'd0);
    check("rlo_oe",        {31'd0, rd_oe},   32'd1);
    check("rlo_data",      {24'd0, rd_byte}, 32'h08);
    cb_data_in = 16'h0000;
    access(1'b0, 1'b0, 1'b0, 10'h13F, 8'h00);
    check("rhi_chrdy_low", low_cnt,          32'd0);
    check("rhi_strobes",   stb_cnt,          32'd0);
    check("rhi_oe",        {31'd0, rd_oe},   32'd1);
    check("rhi_data",      {24'd0, rd_byte}, 32'h42);

    // busy stuck: timeout after 32 SETUP cycles
    cb_busy = 1'b1;
    access(1'b0, 1'b0, 1'b0, 10'h100, 8'h00);
    check("to_chrdy_low", low_cnt,            32'd32);
    check("to_strobes",   stb_cnt,            32'd0);
    check("to_oe",        {31'd0, rd_oe},     32'd1);
    check("to_data",      {24'd0, rd_byte},   32'hFF);
    check("to_err",       {31'd0, cycle_err}, 32'd1);
    access(1'b0, 1'b0, 1'b0, 10'h101, 8'h00);
    check("to_hi_data",   {24'd0, rd_byte},   32'hFF);

    // next successful cycle clears the error and refreshes x_status
    cb_busy = 1'b0; cb_x = 1'b0; cb_data_in = 16'h1234;
    access(1'b0, 1'b0, 1'b0, 10'h100, 8'h00);
    check("ok_err",       {31'd0, cycle_err}, 32'd0);
    check("ok_x",         {31'd0, x_status},  32'd0);
    check("ok_data",      {24'd0, rd_byte},   32'h34);
    check("ok_cb_addr",   {27'd0, a_cap},     32'd0);

    // accesses that must be ignored
    access(1'b0, 1'b0, 1'b0, 10'h0F0, 8'h00);
    check("below_strobes", stb_cnt,        32'd0);
    check("below_chrdy",   low_cnt,        32'd0);
    check("below_oe",      {31'd0, rd_oe}, 32'd0);
    access(1'b1, 1'b0, 1'b0, 10'h140, 8'h55);
    check("above_strobes", stb_cnt,        32'd0);
    check("above_chrdy",   low_cnt,        32'd0);
    access(1'b0, 1'b0, 1'b1, 10'h110, 8'h00);
    check("aen_strobes",   stb_cnt,        32'd0);
    check("aen_chrdy",     low_cnt,        32'd0);
    check("aen_oe",        {31'd0, rd_oe}, 32'd0);
    access(1'b0, 1'b1, 1'b0, 10'h110, 8'h00);
    check("both_strobes",  stb_cnt,        32'd0);
    check("both_chrdy",    low_cnt,        32'd0);
    check("both_oe",       {31'd0, rd_oe}, 32'd0);
    check("ignored_cb_data", {16'd0, cb_data_out}, 32'h4208);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sm2201_camac_cycle_sequencer.md
Name: sm2201_camac_cycle_sequencer

Overview:
- Sequences ISA I/O accesses in the SM2201 window (0x100–0x13F) into 16-bit CAMAC dataway cycles.
- Decodes the address, assembles and splits bytes, and generates CAMAC address, write, strobe and data.
- Holds isa_chrdy low until the CAMAC cycle completes.
- Sits between the ISA bus pins and the CAMAC dataway drivers in sm2201_interface_board.

Parameters:
BASE_ADDR, 10'h100, first ISA address of the window (must be 64-byte aligned)
STROBE_CYCLES, 4, isa_clk cycles cb_strobe is held high (1..15)
TIMEOUT_CYCLES, 32, max isa_clk cycles to wait for cb_busy low before abort (1..255)

Ports:
isa_clk  in  1  bus clock; all logic on rising edge
isa_reset  in  1  synchronous active-high reset
isa_aen  in  1  DMA address enable; high = ignore bus
isa_ior  in  1  I/O read strobe, active low
isa_iow  in  1  I/O write strobe, active low
isa_addr  in  10  I/O address
isa_data_in  in  8  write data from bus
isa_data_out  out  8  read data to bus
isa_data_oe  out  1  drive isa_data_out onto bus
isa_chrdy  out  1  channel ready; low = wait state
cb_addr  out  5  CAMAC subaddress = offset[5:1]
cb_write  out  1  1 = write cycle, 0 = read cycle
cb_strobe  out  1  CAMAC strobe
cb_data_out  out  16  write word
cb_data_in  in  16  read word
cb_busy  in  1  dataway busy
cb_x  in  1  command-accepted response
x_status  out  1  cb_x sampled at end of last strobe
cycle_err  out  1  last CAMAC cycle timed out

Behaviour:
- Reset values: isa_data_out=0, isa_data_oe=0, isa_chrdy=1, cb_addr=0, cb_write=0, cb_strobe=0, cb_data_out=0, x_status=0, cycle_err=0. Low-byte buffer, read latch and FSM cleared; FSM goes to IDLE.
- Reset mid-cycle aborts at the next edge: strobe drops and chrdy returns high.
- Input sampling: isa_ior and isa_iow are registered once. A start is a registered-falling edge of exactly one strobe, with aen=0 and BASE_ADDR <= addr <= BASE_ADDR+63.
  - Both strobes low, aen high, or out-of-range address: no action.
  - Address and data are latched at the start edge; later changes are ignored until return to IDLE.
- Byte mapping: offset = addr-BASE_ADDR. offset[0]=0 is the low byte, 1 is the high byte.
  - Write low: store byte in low buffer; no CAMAC cycle.
  - Write high: cb_data_out={data,lowbuf}; run CAMAC write.
  - Read low: run CAMAC read; return word[7:0].
  - Read high: return latched word[15:8]; no CAMAC cycle.
- isa_chrdy goes low the cycle after the start edge, only for CAMAC-triggering accesses. It stays low until entry to DONE.
- FSM:
  - IDLE: on a non-triggering start go to DONE; on a triggering start go to SETUP.
  - SETUP: cb_addr and cb_write valid. Wait while cb_busy=1. At cb_busy=0 go to STROBE. After TIMEOUT_CYCLES with cb_busy still 1, set cycle_err=1, set read latch=16'hFFFF, go to DONE with no strobe.
  - STROBE: cb_strobe=1 for exactly STROBE_CYCLES cycles. On the last cycle, sample cb_data_in into the read latch (reads only) and cb_x into x_status; clear cycle_err.
  - HOLD: one cycle with strobe low and address/data held.
  - DONE: chrdy=1. For reads, isa_data_oe=1 with the selected byte. Remain in DONE until the registered ior and iow are both high, then go to IDLE with oe=0.
- Latency for a triggering read with cb_busy=0: chrdy low for 1 (SETUP) + STROBE_CYCLES + 1 (HOLD) cycles = 6 at defaults.

Test Plan:
- Reset held 2 cycles mid-STROBE -> next cycle strobe=0, chrdy=1, oe=0, all outputs at reset values.
- Write 0x08 to 0x104, then 0x42 to 0x105, cb_busy=0, cb_x=1 -> one cycle: cb_addr=2, cb_write=1, cb_data_out=16'h4208, strobe high 4 cycles; chrdy low exactly 6 cycles on the second access only; x_status=1.
- cb_data_in=16'h4208; read 0x13E then 0x13F -> cb_addr=31, cb_write=0, one strobe; bus data 0x08 then 0x42; second read has no strobe and no chrdy drop.
- cb_busy stuck 1; read 0x100 -> no strobe, chrdy released after 32 SETUP cycles, data 0xFF, cycle_err=1. The next successful cycle clears cycle_err.
- Accesses at 0x0F0 and 0x140, with aen=1 at 0x110, and with ior and iow low together -> no strobe, chrdy stays 1, oe stays 0.
